serial_tx_arbiter: RTL
======================

SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit time (legal range 2..1023).
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: req0  input  1  requester 0 has a byte to send; held high until gnt0.
REQ-005 Port: data0  input  8  requester 0 byte; held stable while req0 is high.
REQ-006 Port: gnt0  output  1  one-cycle pulse; data0 has been captured.
REQ-007 Port: req1  input  1  requester 1 has a byte to send; held high until gnt1.
REQ-008 Port: data1  input  8  requester 1 byte; held stable while req1 is high.
REQ-009 Port: gnt1  output  1  one-cycle pulse; data1 has been captured.
REQ-010 Port: serial_out  output  1  registered serial line; idle level 1.
REQ-011 Port: busy  output  1  1 whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY (present only with the macro in REQ-027) and STOP.
REQ-013 In IDLE with req0 or req1 high, the next edge SHALL do four things: capture the winner's byte, pulse its gnt for exactly one cycle, enter START, and drive serial_out to 0.
REQ-014 Arbitration SHALL be round-robin via a 1-bit last-grant pointer.
- Only one requester high: that requester wins.
- Both high: the requester not granted last wins.
- Pointer updates on every grant.
REQ-015 gnt0 and gnt1 SHALL never be high in the same cycle, and SHALL never pulse outside a grant edge.
REQ-016 A requester that drops req before its grant SHALL not be served; no partial frame is sent.
REQ-017 Bit timing: a baud counter SHALL hold each serial_out bit for exactly CLKS_PER_BIT cycles, counting 0..CLKS_PER_BIT-1 and reloading 0 on each bit boundary.
REQ-018 DATA SHALL shift the captured byte out LSB first.
- A 3-bit bit index runs 0..7.
- DATA exits after bit 7's final cycle.
REQ-019 STOP SHALL drive serial_out to 1 for one bit time.
REQ-020 At the end of STOP with any req high, the FSM SHALL grant per REQ-013/014 on that same edge and go directly to START (no idle gap); with no req high, it SHALL go to IDLE.
REQ-021 Frame length from grant edge to end of STOP SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with the REQ-027 macro defined).
REQ-022 Requests arriving mid-frame SHALL be ignored until the STOP-end edge; the captured byte SHALL not change mid-frame.
REQ-023 busy SHALL be 1 from the grant edge through the last STOP cycle, and SHALL be 0 in IDLE.

Reset
REQ-024 While reset = 0, the following SHALL hold immediately (asynchronously), including mid-frame:
- FSM in IDLE, serial_out = 1, gnt0 = gnt1 = 0, busy = 0.
- Baud counter and bit index = 0; captured byte = 0x00.
- Last-grant pointer = 1, so requester 0 wins the first tie.
REQ-025 The first grant after reset release SHALL occur no earlier than the first rising edge with reset = 1.
REQ-026 A frame cut by reset SHALL not resume; a requester whose gnt already pulsed SHALL not be re-granted for that byte.

Configuration
REQ-027 Macro SERIAL_TX_ARBITER_PARITY_EN.
- Defined: a PARITY state SHALL follow DATA, driving the even-parity bit (XOR of the 8 data bits) for one bit time before STOP.
- Undefined: DATA SHALL go directly to STOP; no parity logic or state encoding is present.

Verification
REQ-028 CLKS_PER_BIT = 4; reset released; req0 = 1, data0 = 0xA5 -> gnt0 pulses 1 cycle; serial_out sequence, 4 cycles each, is 0,1,0,1,0,0,1,0,1,1; busy low after 40 cycles.
REQ-029 req0 and req1 both high from reset release (data0 = 0x11, data1 = 0x22) -> frame 0x11 (gnt0), then frame 0x22 (gnt1) starts on the STOP-end edge with no idle cycle.
REQ-030 req0 held high continuously while req1 pulses 2 cycles mid-frame and then stays low -> req1 is not granted; after the frame, gnt0 repeats back-to-back.
REQ-031 reset = 0 asserted in DATA at bit 3 -> serial_out = 1 and busy = 0 in the same cycle; after release with req1 = 1, the next frame starts cleanly with gnt1.
REQ-032 Macro defined, data0 = 0x07 -> parity bit 1 after bit 7; frame length 44 cycles. Macro undefined -> frame length 40 cycles.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// ============================================================================
// Module   : serial_tx_arbiter
// Brief    : Two-requester round-robin arbiter feeding an 8N1 serial framer.
//            Optional even-parity bit enabled by SERIAL_TX_ARBITER_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_tx_arbiter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       gnt0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       gnt1,
   output logic       serial_out,
   output logic       busy
);

`ifdef SERIAL_TX_ARBITER_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd4
   } state_t;
`endif

   localparam logic [9:0] c_BAUD_LAST = 10'(CLKS_PER_BIT - 1);

   state_t     r_state;
   logic [9:0] r_baud;
   logic [2:0] r_bit_idx;
   logic [7:0] r_data;
   logic       r_last;
   logic       r_gnt0;
   logic       r_gnt1;
   logic       r_serial;

   logic       w_any_req;
   logic       w_pick1;
   logic       w_bit_end;
   logic       w_grant;
   logic [2:0] w_next_idx;

   assign w_any_req  = req0 | req1;
   // Requester 1 wins when alone, or on a tie when requester 0 was served last.
   assign w_pick1    = req1 & (~req0 | ~r_last);
   assign w_bit_end  = (r_baud == c_BAUD_LAST);
   assign w_grant    = w_any_req & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
   assign w_next_idx = r_bit_idx + 3'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_data    <= '0;
         r_last    <= 1'b1;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_serial  <= 1'b1;
      end else begin
         r_gnt0 <= 1'b0;
         r_gnt1 <= 1'b0;
         if (w_grant) begin
            // Same edge serves IDLE pickup and back-to-back STOP-end handover.
            r_state   <= S_START;
            r_serial  <= 1'b0;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_data    <= w_pick1 ? data1 : data0;
            r_gnt0    <= ~w_pick1;
            r_gnt1    <= w_pick1;
            r_last    <= w_pick1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_serial <= 1'b1;
                  r_baud   <= '0;
               end
               S_START: begin
                  if (w_bit_end) begin
                     r_baud    <= '0;
                     r_bit_idx <= '0;
                     r_serial  <= r_data[0];
                     r_state   <= S_DATA;
                  end else begin
                     r_baud <= r_baud + 10'd1;
                  end
               end
               S_DATA: begin
                  if (w_bit_end) begin
                     r_baud <= '0;
                     if (r_bit_idx == 3'd7) begin
`ifdef SERIAL_TX_ARBITER_PARITY_EN
                        r_serial <= ^r_data;
                        r_state  <= S_PARITY;
`else
                        r_serial <= 1'b1;
                        r_state  <= S_STOP;
`endif
                     end else begin
                        r_bit_idx <= w_next_idx;
                        r_serial  <= r_data[w_next_idx];
                     end
                  end else begin
                     r_baud <= r_baud + 10'd1;
                  end
               end
`ifdef SERIAL_TX_ARBITER_PARITY_EN
               S_PARITY: begin
                  if (w_bit_end) begin
                     r_baud   <= '0;
                     r_serial <= 1'b1;
                     r_state  <= S_STOP;
                  end else begin
                     r_baud <= r_baud + 10'd1;
                  end
               end
`endif
               S_STOP: begin
                  if (w_bit_end) begin
                     r_baud   <= '0;
                     r_serial <= 1'b1;
                     r_state  <= S_IDLE;
                  end else begin
                     r_baud <= r_baud + 10'd1;
                  end
               end
               default: begin
                  r_state  <= S_IDLE;
                  r_baud   <= '0;
                  r_serial <= 1'b1;
               end
            endcase
         end
      end
   end

   assign gnt0       = r_gnt0;
   assign gnt1       = r_gnt1;
   assign serial_out = r_serial;
   assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire
